// File: rtl/vga_rx.sv
// VGA timing receiver: recovers pixel coordinates, verifies line/frame timing, locks.
// Optional per-frame RGB checksum on frame_sum when VGA_RX_CHECKSUM_EN is defined.
module vga_rx #(
  parameter int H_TOTAL  = 800,
  parameter int H_ACTIVE = 640,
  parameter int V_TOTAL  = 525,
  parameter int V_ACTIVE = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync_n,
  input  logic        vsync_n,
  input  logic        blank_n,
  input  logic [7:0]  red,
  input  logic [7:0]  green,
  input  logic [7:0]  blue,
  input  logic        err_clr,
  output logic        pixel_valid,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [23:0] pixel_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_error,
  output logic [15:0] frame_count,
  output logic [23:0] frame_sum
);

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  localparam logic [10:0] H_TOT = 11'(H_TOTAL);
  localparam logic [9:0]  H_ACT = 10'(H_ACTIVE);
  localparam logic [10:0] V_TOT = 11'(V_TOTAL);
  localparam logic [9:0]  V_ACT = 10'(V_ACTIVE);

  logic        hs_reg, hs_prev_reg, vs_reg, vs_prev_reg, blank_reg, clr_reg;
  logic [23:0] rgb_reg;
  state_t      state_reg, state_next;
  logic [10:0] h_len_reg, h_len_next;
  logic [9:0]  act_cnt_reg, act_cnt_next, act_base;
  logic [10:0] line_cnt_reg, line_cnt_eff, line_cnt_next;
  logic [9:0]  act_lines_reg, act_lines_eff, act_lines_next;
  logic        meas_bad_reg, meas_bad_next;
  logic        line_start, frame_edge, line_err, frame_err;
  logic        fs_pulse, count_inc, err_set, pv_next;

  assign line_start = hs_prev_reg & ~hs_reg;
  assign frame_edge = vs_prev_reg & ~vs_reg;
  assign pv_next    = (state_reg == LOCKED) && blank_reg;

  // Syncs reset to their inactive level so release never fakes an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_reg      <= 1'b1;
      hs_prev_reg <= 1'b1;
      vs_reg      <= 1'b1;
      vs_prev_reg <= 1'b1;
      blank_reg   <= 1'b0;
      clr_reg     <= 1'b0;
      rgb_reg     <= '0;
    end else begin
      hs_reg      <= hsync_n;
      hs_prev_reg <= hs_reg;
      vs_reg      <= vsync_n;
      vs_prev_reg <= vs_reg;
      blank_reg   <= blank_n;
      clr_reg     <= err_clr;
      rgb_reg     <= {red, green, blue};
    end
  end

  // Line end is accounted before frame start so a coincident new line is line 0.
  always_comb begin
    line_err      = 1'b0;
    act_base      = line_start ? 10'd0 : act_cnt_reg;
    act_cnt_next  = act_base;
    if (blank_reg && act_base != 10'h3FF) act_cnt_next = act_base + 10'd1;
    h_len_next    = h_len_reg;
    if (line_start)                 h_len_next = 11'd1;
    else if (h_len_reg != 11'h7FF)  h_len_next = h_len_reg + 11'd1;
    line_cnt_eff  = line_cnt_reg;
    act_lines_eff = act_lines_reg;
    if (line_start) begin
      if (line_cnt_reg != 11'h7FF) line_cnt_eff = line_cnt_reg + 11'd1;
      if (act_cnt_reg != 10'd0 && act_lines_reg != 10'h3FF) act_lines_eff = act_lines_reg + 10'd1;
      line_err = (h_len_reg != H_TOT) || (act_cnt_reg != 10'd0 && act_cnt_reg != H_ACT);
    end
    frame_err      = frame_edge && (line_cnt_eff != V_TOT || act_lines_eff != V_ACT);
    line_cnt_next  = frame_edge ? 11'd0 : line_cnt_eff;
    act_lines_next = frame_edge ? 10'd0 : act_lines_eff;
  end

  always_comb begin
    state_next    = state_reg;
    meas_bad_next = meas_bad_reg;
    fs_pulse      = 1'b0;
    count_inc     = 1'b0;
    err_set       = 1'b0;
    case (state_reg)
      SEARCH: begin
        if (frame_edge) begin
          state_next    = MEASURE;
          meas_bad_next = 1'b0;
        end
      end
      MEASURE: begin
        if (line_err) meas_bad_next = 1'b1;
        if (frame_edge) begin
          if (!(meas_bad_reg || line_err || frame_err)) begin
            state_next = LOCKED;
            fs_pulse   = 1'b1;
          end
          meas_bad_next = 1'b0;
        end
      end
      LOCKED: begin
        if (line_err || frame_err) begin
          state_next = SEARCH;
          err_set    = 1'b1;
        end else if (frame_edge) begin
          fs_pulse  = 1'b1;
          count_inc = 1'b1;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= SEARCH;
      h_len_reg     <= '0;
      act_cnt_reg   <= '0;
      line_cnt_reg  <= '0;
      act_lines_reg <= '0;
      meas_bad_reg  <= 1'b0;
      pixel_valid   <= 1'b0;
      pixel_x       <= '0;
      pixel_y       <= '0;
      pixel_rgb     <= '0;
      frame_start   <= 1'b0;
      locked        <= 1'b0;
      timing_error  <= 1'b0;
      frame_count   <= '0;
    end else begin
      state_reg     <= state_next;
      h_len_reg     <= h_len_next;
      act_cnt_reg   <= act_cnt_next;
      line_cnt_reg  <= line_cnt_next;
      act_lines_reg <= act_lines_next;
      meas_bad_reg  <= meas_bad_next;
      pixel_valid   <= pv_next;
      if (pv_next) begin
        pixel_x   <= act_base;
        pixel_y   <= act_lines_next;
        pixel_rgb <= rgb_reg;
      end
      frame_start <= fs_pulse;
      locked      <= (state_next == LOCKED);
      if (err_set)      timing_error <= 1'b1;
      else if (clr_reg) timing_error <= 1'b0;
      if (count_inc) frame_count <= frame_count + 16'd1;
    end
  end

`ifdef VGA_RX_CHECKSUM_EN
  logic [23:0] run_sum_reg, sum_add;
  assign sum_add = pv_next ? rgb_reg : 24'd0;

  // The pixel on a frame-start clock belongs to the new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_sum_reg <= '0;
      frame_sum   <= '0;
    end else if (fs_pulse) begin
      frame_sum   <= run_sum_reg;
      run_sum_reg <= sum_add;
    end else if (state_reg != LOCKED) begin
      run_sum_reg <= '0;
    end else begin
      run_sum_reg <= run_sum_reg + sum_add;
    end
  end
`else
  assign frame_sum = 24'd0;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// Randomized scoreboard bench for vga_rx on a scaled-down raster (20x12 total, 12x8 active).
module tb_vga_rx;
  localparam int H_T = 20, H_A = 12, V_T = 12, V_A = 8;
  localparam int HA0 = 5, VA0 = 2;
  localparam int SR = 0, MS = 1, LK = 2;

  logic        clk, rst, hsync_n, vsync_n, blank_n, err_clr;
  logic [23:0] rgbv;
  logic [7:0]  red, green, blue;
  logic        pixel_valid, frame_start, locked, timing_error;
  logic [9:0]  pixel_x, pixel_y;
  logic [23:0] pixel_rgb, frame_sum;
  logic [15:0] frame_count;

  assign {red, green, blue} = rgbv;

  vga_rx #(.H_TOTAL(H_T), .H_ACTIVE(H_A), .V_TOTAL(V_T), .V_ACTIVE(V_A)) dut (
    .clk(clk), .rst(rst), .hsync_n(hsync_n), .vsync_n(vsync_n), .blank_n(blank_n),
    .red(red), .green(green), .blue(blue), .err_clr(err_clr),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_rgb(pixel_rgb),
    .frame_start(frame_start), .locked(locked), .timing_error(timing_error),
    .frame_count(frame_count), .frame_sum(frame_sum)
  );

  typedef struct { int x; int y; logic [23:0] rgb; int cyc; } pix_t;
  typedef struct { logic [15:0] cnt; logic [23:0] sum; int cyc; } ev_t;
  typedef struct { int cyc; int kind; logic lk; logic te; logic [15:0] fc; } st_t;

  pix_t pq[$];
  ev_t  eq[$];
  st_t  sq[$];

  int total = 0, bad = 0, cyc = 0;
  bit done = 0, fin = 0;

  // Frame-level reference state
  int          mstate;
  bit          meas_bad, last_short, exp_te;
  logic [15:0] fc;
  logic [23:0] sum_acc;

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  pix_t mp; ev_t me; st_t ms;
  always @(negedge clk) begin
    if (rst) begin
      if (pixel_valid) begin
        if (pq.size() == 0) chk("pix_unexpected", 32'(pixel_valid), 32'd0);
        else begin
          mp = pq.pop_front();
          chk("pix_x", 32'(pixel_x), 32'(mp.x));
          chk("pix_y", 32'(pixel_y), 32'(mp.y));
          chk("pix_rgb", 32'(pixel_rgb), 32'(mp.rgb));
          chk("pix_latency", 32'(cyc), 32'(mp.cyc));
        end
      end
      if (frame_start) begin
        if (eq.size() == 0) chk("fs_unexpected", 32'(frame_start), 32'd0);
        else begin
          me = eq.pop_front();
          chk("fs_count", 32'(frame_count), 32'(me.cnt));
          chk("fs_sum", 32'(frame_sum), 32'(me.sum));
          chk("fs_latency", 32'(cyc), 32'(me.cyc));
        end
      end
    end
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      ms = sq.pop_front();
      if (ms.kind == 0) begin
        chk("st_locked", 32'(locked), 32'(ms.lk));
        chk("st_terr", 32'(timing_error), 32'(ms.te));
        chk("st_fcount", 32'(frame_count), 32'(ms.fc));
      end else if (ms.kind == 2) begin
        chk("clr_terr", 32'(timing_error), 32'(ms.te));
      end else begin
        chk("rst_pv", 32'(pixel_valid), 32'd0);
        chk("rst_fs", 32'(frame_start), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_terr", 32'(timing_error), 32'd0);
        chk("rst_xy", 32'({pixel_x, pixel_y}), 32'd0);
        chk("rst_rgb", 32'(pixel_rgb), 32'd0);
        chk("rst_fcount", 32'(frame_count), 32'd0);
        chk("rst_fsum", 32'(frame_sum), 32'd0);
      end
    end
    if (done && !fin) begin
      fin = 1;
      chk("pix_left", 32'(pq.size()), 32'd0);
      chk("fs_left", 32'(eq.size()), 32'd0);
      chk("st_left", 32'(sq.size()), 32'd0);
    end
  end

  task automatic model_reset();
    mstate = SR; meas_bad = 0; last_short = 0; exp_te = 0; fc = 0; sum_acc = 0;
  endtask

  // Reference reaction to one driven clock; outputs appear two cycles later.
  task automatic model_step(input int l, input int c, input int short_line);
    bit err_set = 0;
    logic [23:0] evsum;
    if (c == 0) begin
      case (mstate)
        LK: if (last_short) begin mstate = SR; exp_te = 1; err_set = 1; end
            else if (l == 0) begin
              fc = fc + 16'd1;
`ifdef VGA_RX_CHECKSUM_EN
              evsum = sum_acc;
`else
              evsum = 24'd0;
`endif
              eq.push_back('{fc, evsum, cyc + 2});
            end
        MS: begin
          if (last_short) meas_bad = 1;
          if (l == 0) begin
            if (!meas_bad) begin mstate = LK; eq.push_back('{fc, 24'd0, cyc + 2}); end
            meas_bad = 0;
          end
        end
        default: if (l == 0) begin mstate = MS; meas_bad = 0; end
      endcase
      if (l == 0) sum_acc = 0;
      last_short = (l == short_line);
    end
    if (err_clr && !err_set) exp_te = 0;
    if (blank_n && mstate == LK) begin
      pq.push_back('{c - HA0, l - VA0, rgbv, cyc + 2});
      sum_acc = sum_acc + rgbv;
    end
  endtask

  task automatic drive_frame(input int short_line, input bit const_rgb, input int clr_line, input int rst_line);
    int len;
    for (int l = 0; l < V_T; l++) begin
      len = (l == short_line) ? H_T - 1 : H_T;
      for (int c = 0; c < len; c++) begin
        @(posedge clk); #1;
        hsync_n = (c >= 2);
        vsync_n = (l >= 2);
        blank_n = (l >= VA0 && l < VA0 + V_A && c >= HA0 && c < HA0 + H_A);
        rgbv    = const_rgb ? 24'h000001 : 24'($urandom);
        err_clr = (l == clr_line && c < 2);
        if (l == rst_line && c == 7) begin
          rst = 0;
          sq.push_back('{cyc, 1, 1'b0, 1'b0, 16'd0});
          model_reset();
        end
        if (l == rst_line && c == 9) rst = 1;
        if (rst) model_step(l, c, short_line);
        if (l == clr_line && c < 2) sq.push_back('{cyc + 2, 2, 1'b0, exp_te, 16'd0});
      end
    end
    sq.push_back('{cyc + 2, 0, (mstate == LK), exp_te, fc});
  endtask

  task automatic relock();
    drive_frame(-1, 0, -1, -1);
    drive_frame(-1, 0, -1, -1);
    for (int k = 0; k < 3 && mstate != LK; k++) drive_frame(-1, 0, -1, -1);
  endtask

  initial begin
    rst = 0; hsync_n = 1; vsync_n = 1; blank_n = 0; rgbv = 0; err_clr = 0;
    model_reset();
    @(posedge clk); #1;
    sq.push_back('{cyc, 1, 1'b0, 1'b0, 16'd0});
    @(posedge clk); #1;
    rst = 1;
    repeat (3) drive_frame(-1, 0, -1, -1);
    drive_frame(-1, 1, -1, -1);
    drive_frame(-1, 0, -1, -1);
    drive_frame($urandom_range(VA0 + V_A, V_T - 1), 0, -1, -1);
    relock();
    drive_frame(VA0 + V_A, 0, VA0 + V_A + 1, -1);
    relock();
    drive_frame(-1, 0, -1, VA0 + V_A);
    repeat (4) drive_frame(-1, 0, -1, -1);
    repeat (4) @(posedge clk);
    #1 done = 1;
    @(negedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_rx.md
VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 Parameters: H_TOTAL default 800, clocks per line; H_ACTIVE default 640, active pixels per line; V_TOTAL default 525, lines per frame; V_ACTIVE default 480, active lines per frame.
REQ-002 clk  input  1  pixel clock; all logic on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 hsync_n  input  1  horizontal sync, active low.
REQ-005 vsync_n  input  1  vertical sync, active low.
REQ-006 blank_n  input  1  high = active video pixel.
REQ-007 red, green, blue  input  8 each  pixel colour.
REQ-008 err_clr  input  1  single-cycle pulse, clears timing_error.
REQ-009 pixel_valid  output  1  captured active pixel on pixel_x/pixel_y/pixel_rgb.
REQ-010 pixel_x, pixel_y  output  10 each  recovered coordinates.
REQ-011 pixel_rgb  output  24  {red,green,blue} of the captured pixel.
REQ-012 frame_start  output  1  one-cycle pulse at each vsync_n falling edge while locked.
REQ-013 locked  output  1  timing verified against parameters.
REQ-014 timing_error  output  1  sticky error flag.
REQ-015 frame_count  output  16  frames completed while locked; wraps 65535 -> 0.
REQ-016 frame_sum  output  24  per-frame checksum (see Configuration).

Function
REQ-017 All inputs registered once; edges detected on registered values; all outputs registered, 2 clk after the corresponding input sample.
REQ-018 Line start = hsync_n falling edge; frame start = vsync_n falling edge.
REQ-019 h_len counter counts clocks between line starts, saturating at 2047; active-pixel counter counts blank_n-high clocks per line, saturating at 1023.
REQ-020 Line check at each line start: error if h_len != H_TOTAL, or if the line had any active pixel and active count != H_ACTIVE.
REQ-021 Frame check at each frame start: error if lines since previous frame start != V_TOTAL, or if lines with active pixels != V_ACTIVE.
REQ-022 States: SEARCH, MEASURE, LOCKED.
REQ-023 SEARCH -> MEASURE on first frame start; counters cleared at that edge.
REQ-024 MEASURE -> LOCKED at next frame start if no line/frame error occurred during the frame; else back to MEASURE with counters cleared, timing_error not set.
REQ-025 LOCKED -> SEARCH on any line or frame error; timing_error set the same cycle locked drops.
REQ-026 locked = 1 only in LOCKED.
REQ-027 pixel_valid = 1 only in LOCKED with blank_n high; pixel_x = active index within line (0..H_ACTIVE-1); pixel_y = active line index within frame (0..V_ACTIVE-1).
REQ-028 frame_start and frame_count increment occur only at frame starts where the state is, and remains, LOCKED (including the MEASURE->LOCKED transition edge: frame_start asserted, frame_count not incremented).
REQ-029 err_clr clears timing_error; an error in the same cycle as err_clr wins (flag stays 1).
REQ-030 hsync_n and vsync_n falling in the same cycle: process line start then frame start (the new line is line 0).

Reset
REQ-031 On rst low, immediately: state SEARCH; all counters 0; pixel_valid, frame_start, locked, timing_error 0; pixel_x, pixel_y, pixel_rgb, frame_count, frame_sum 0.
REQ-032 Reset deasserted mid-frame: remain in SEARCH until next vsync_n falling edge; no error raised for the partial frame.

Configuration
REQ-033 Macro VGA_RX_CHECKSUM_EN defined: running sum modulo 2^24 of pixel_rgb over all pixel_valid cycles; latched into frame_sum at each locked frame start, running sum then cleared.
REQ-034 Macro undefined: frame_sum tied to 0, no checksum logic.

Verification
REQ-035 Standard 640x480 timing (800x525, active low syncs) from reset -> locked rises at 2nd vsync fall, frame_count 0; 3rd vsync fall -> frame_count 1, frame_start pulses once.
REQ-036 Locked, one line shortened to 799 clocks -> at that line end locked 0, timing_error 1, state SEARCH; relock after two further good frames.
REQ-037 Locked, frame of constant RGB 0x000001 with VGA_RX_CHECKSUM_EN -> frame_sum = 307200 (0x04B000) at next frame start; without macro frame_sum stays 0.
REQ-038 Locked, pixel at line 10, column 5 -> pixel_valid 1 with pixel_x 5, pixel_y 10, 2 clk after sample; pixel_valid 0 during blanking.
REQ-039 timing_error set, err_clr pulsed coincident with a new line error -> timing_error remains 1; err_clr alone next cycle -> 0.
REQ-040 rst asserted mid-frame while locked -> all outputs 0 immediately; after release, no lock until 2nd full vsync fall.
